// File: rtl/bmp_bound_scanner_pkg.sv
// Shared sizes, index widths and lane state encoding for the bitmap bounding-box scanner.
package bmp_bound_scanner_pkg;
   localparam int DEF_ROWS     = 64;
   localparam int DEF_COLS     = 24;
   localparam int ROW_IW       = 6;
   localparam int COL_IW       = 5;
   localparam int DEF_WAIT_MAX = 15;

   typedef enum logic [2:0] {
      L_IDLE = 3'd0,
      L_REQ  = 3'd1,
      L_WAIT = 3'd2,
      L_EVAL = 3'd3,
      L_FIN  = 3'd4
   } lane_state_t;
endpackage

// File: rtl/bmp_scan_lane.sv
// One request/ready lane: issues a one-cycle request, waits for ready (with timeout),
// captures the slice and steps its index counter toward END.
//
// Handshake: req is high exactly one cycle (state L_REQ); ready is honoured only in
// L_WAIT, and slice_in is captured in the cycle ready is high. Ready seen in any
// other state is dropped.
module bmp_scan_lane
   import bmp_bound_scanner_pkg::*;
#(
   parameter int              W        = 24,
   parameter int              IW       = 6,
   parameter logic [IW-1:0]   START    = '0,
   parameter logic [IW-1:0]   END      = '0,
   parameter bit              DESC     = 1'b0,
   parameter int              WAIT_MAX = DEF_WAIT_MAX
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          clear,
   input  logic          ready,
   input  logic [W-1:0]  slice_in,
   input  logic          stop,
   output logic          req,
   output lane_state_t   state,
   output logic [IW-1:0] idx,
   output logic [W-1:0]  slice_q,
   output logic          timed_out
);
   localparam int WCW = $clog2(WAIT_MAX + 1);
   localparam logic [WCW-1:0] WAIT_LAST = WCW'(WAIT_MAX - 1);

   logic [WCW-1:0] wcnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= L_IDLE;
         req       <= 1'b0;
         idx       <= '0;
         slice_q   <= '0;
         wcnt      <= '0;
         timed_out <= 1'b0;
      end else begin
         req <= 1'b0;
         if (start) begin
            state     <= L_REQ;
            req       <= 1'b1;
            idx       <= START;
            wcnt      <= '0;
            timed_out <= 1'b0;
         end else begin
            case (state)
               L_IDLE: state <= L_IDLE;
               L_REQ: begin
                  state <= L_WAIT;
                  wcnt  <= '0;
               end
               L_WAIT: begin
                  if (ready) begin
                     slice_q <= slice_in;
                     state   <= L_EVAL;
                  end else if (wcnt == WAIT_LAST) begin
                     timed_out <= 1'b1;
                     state     <= L_FIN;
                  end else begin
                     wcnt <= wcnt + 1'b1;
                  end
               end
               L_EVAL: begin
                  // Finishing on END keeps the counter from ever wrapping.
                  if (stop || idx == END) begin
                     state <= L_FIN;
                  end else begin
                     idx   <= DESC ? idx - 1'b1 : idx + 1'b1;
                     state <= L_REQ;
                     req   <= 1'b1;
                  end
               end
               L_FIN: if (clear) state <= L_IDLE;
               default: state <= L_IDLE;
            endcase
         end
      end
   end
endmodule

// File: rtl/bmp_bound_scanner.sv
// Bitmap bounding-box scanner: three lanes (top rows, bottom rows, columns) feed the
// result registers; done pulses once when every lane has finished.
module bmp_bound_scanner
   import bmp_bound_scanner_pkg::*;
#(
   parameter int ROWS     = DEF_ROWS,
   parameter int COLS     = DEF_COLS,
   parameter int WAIT_MAX = DEF_WAIT_MAX
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              alustart,
   input  logic [ROWS-1:0]   columnin,
   input  logic [COLS-1:0]   toprowin,
   input  logic [COLS-1:0]   botrowin,
   input  logic              colready,
   input  logic              rowtopready,
   input  logic              rowbotready,
   input  logic              finalcolumn,
   output logic              nextcol,
   output logic              nextrowtop,
   output logic              nextrowbot,
   output logic              busy,
   output logic              done,
   output logic              empty,
   output logic              timeout,
   output logic [ROW_IW-1:0] top_idx,
   output logic [ROW_IW-1:0] bot_idx,
   output logic [COL_IW-1:0] col_hi,
   output logic [COL_IW-1:0] col_lo
);
   lane_state_t       st_t, st_b, st_c;
   logic [ROW_IW-1:0] idx_t, idx_b;
   logic [COL_IW-1:0] idx_c;
   logic [COLS-1:0]   slice_t, slice_b;
   logic [ROWS-1:0]   slice_c;
   logic              to_t, to_b, to_c;
   logic              all_fin, col_found, final_q;

   assign all_fin = (st_t == L_FIN) && (st_b == L_FIN) && (st_c == L_FIN);

   bmp_scan_lane #(
      .W(COLS), .IW(ROW_IW), .START(ROW_IW'(ROWS - 1)), .END('0),
      .DESC(1'b1), .WAIT_MAX(WAIT_MAX)
   ) u_top (
      .clk(clk), .rst(rst), .start(alustart), .clear(all_fin),
      .ready(rowtopready), .slice_in(toprowin), .stop(|slice_t),
      .req(nextrowtop), .state(st_t), .idx(idx_t), .slice_q(slice_t),
      .timed_out(to_t)
   );

   bmp_scan_lane #(
      .W(COLS), .IW(ROW_IW), .START('0), .END(ROW_IW'(ROWS - 1)),
      .DESC(1'b0), .WAIT_MAX(WAIT_MAX)
   ) u_bot (
      .clk(clk), .rst(rst), .start(alustart), .clear(all_fin),
      .ready(rowbotready), .slice_in(botrowin), .stop(|slice_b),
      .req(nextrowbot), .state(st_b), .idx(idx_b), .slice_q(slice_b),
      .timed_out(to_b)
   );

   bmp_scan_lane #(
      .W(ROWS), .IW(COL_IW), .START(COL_IW'(COLS - 1)), .END('0),
      .DESC(1'b1), .WAIT_MAX(WAIT_MAX)
   ) u_col (
      .clk(clk), .rst(rst), .start(alustart), .clear(all_fin),
      .ready(colready), .slice_in(columnin), .stop(final_q),
      .req(nextcol), .state(st_c), .idx(idx_c), .slice_q(slice_c),
      .timed_out(to_c)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy      <= 1'b0;
         done      <= 1'b0;
         empty     <= 1'b0;
         timeout   <= 1'b0;
         top_idx   <= '0;
         bot_idx   <= '0;
         col_hi    <= '0;
         col_lo    <= '0;
         col_found <= 1'b0;
         final_q   <= 1'b0;
      end else if (alustart) begin
         // A start while busy silently discards the scan in flight.
         busy      <= 1'b1;
         done      <= 1'b0;
         empty     <= 1'b0;
         timeout   <= 1'b0;
         top_idx   <= '0;
         bot_idx   <= '0;
         col_hi    <= '0;
         col_lo    <= '0;
         col_found <= 1'b0;
         final_q   <= 1'b0;
      end else begin
         done    <= 1'b0;
         timeout <= timeout | to_t | to_b | to_c;
         if (st_t == L_EVAL && |slice_t) top_idx <= idx_t;
         if (st_b == L_EVAL && |slice_b) bot_idx <= idx_b;
         if (st_c == L_EVAL && |slice_c) begin
            if (!col_found) col_hi <= idx_c;
            col_lo    <= idx_c;
            col_found <= 1'b1;
         end
         if (st_c == L_WAIT && colready) final_q <= finalcolumn;
         if (all_fin) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            empty <= !col_found;
            if (!col_found) begin
               top_idx <= '0;
               bot_idx <= '0;
               col_hi  <= '0;
               col_lo  <= '0;
            end
         end
      end
   end
endmodule

// File: tb/tb_bmp_bound_scanner.sv
// Directed bench for bmp_bound_scanner: a behavioural slice provider answers each
// request one cycle later from a bitmap array; results are checked against tables.
module tb_bmp_bound_scanner;
   localparam int ROWS = 64;
   localparam int COLS = 24;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            alustart = 1'b0;
   logic [ROWS-1:0] columnin = '0;
   logic [COLS-1:0] toprowin = '0;
   logic [COLS-1:0] botrowin = '0;
   logic            colready = 1'b0;
   logic            rowtopready = 1'b0;
   logic            rowbotready = 1'b0;
   logic            finalcolumn = 1'b0;
   logic            nextcol, nextrowtop, nextrowbot;
   logic            busy, done, empty, timeout;
   logic [5:0]      top_idx, bot_idx;
   logic [4:0]      col_hi, col_lo;

   bmp_bound_scanner dut (
      .clk(clk), .rst(rst), .alustart(alustart),
      .columnin(columnin), .toprowin(toprowin), .botrowin(botrowin),
      .colready(colready), .rowtopready(rowtopready), .rowbotready(rowbotready),
      .finalcolumn(finalcolumn),
      .nextcol(nextcol), .nextrowtop(nextrowtop), .nextrowbot(nextrowbot),
      .busy(busy), .done(done), .empty(empty), .timeout(timeout),
      .top_idx(top_idx), .bot_idx(bot_idx), .col_hi(col_hi), .col_lo(col_lo)
   );

   // ---------------- clock ----------------
   initial forever #5 clk = ~clk;

   // ---------------- provider model ----------------
   logic [COLS-1:0] bitmap [ROWS];
   bit  mute_bot = 1'b0;
   bit  pend_t, pend_b, pend_c;
   int  tidx, bidx, cidx;
   int  ntop, nbot, ncol;
   int  done_cnt = 0;

   initial begin
      pend_t = 0; pend_b = 0; pend_c = 0;
      tidx = ROWS - 1; bidx = 0; cidx = COLS - 1;
      ntop = 0; nbot = 0; ncol = 0;
      forever begin
         @(posedge clk);
         #1;
         if (rst || alustart) begin
            pend_t = 0; pend_b = 0; pend_c = 0;
            tidx = ROWS - 1; bidx = 0; cidx = COLS - 1;
            ntop = 0; nbot = 0; ncol = 0;
         end
         rowtopready = pend_t;
         if (pend_t && tidx >= 0) begin
            toprowin = bitmap[tidx];
            tidx--;
         end
         rowbotready = pend_b && !mute_bot;
         if (pend_b && bidx < ROWS) begin
            botrowin = bitmap[bidx];
            bidx++;
         end
         colready    = pend_c;
         finalcolumn = 1'b0;
         if (pend_c && cidx >= 0) begin
            for (int r = 0; r < ROWS; r++) columnin[r] = bitmap[r][cidx];
            finalcolumn = (cidx == 0);
            cidx--;
         end
         pend_t = nextrowtop && !rst;
         pend_b = nextrowbot && !rst;
         pend_c = nextcol && !rst;
         if (nextrowtop) ntop++;
         if (nextrowbot) nbot++;
         if (nextcol)    ncol++;
      end
   end

   always @(negedge clk) if (done) done_cnt++;

   // ---------------- scoreboard ----------------
   int n_pass = 0;
   int n_total = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
   endtask

   // ---------------- driver tasks ----------------
   task automatic clear_bitmap();
      for (int r = 0; r < ROWS; r++) bitmap[r] = '0;
   endtask

   task automatic pulse_start();
      @(negedge clk);
      alustart = 1'b1;
      @(negedge clk);
      alustart = 1'b0;
   endtask

   task automatic wait_done(input string nm);
      bit got = 0;
      for (int i = 0; i < 3000; i++) begin
         if (done) begin
            got = 1;
            break;
         end
         @(negedge clk);
      end
      chk({nm, "_done_seen"}, int'(got), 1);
   endtask

   typedef struct {
      int r0, c0, r1, c1;
      bit p0, p1, mute;
      int e_top, e_bot, e_hi, e_lo;
      bit e_empty, e_to;
      int n_top, n_bot, n_col;
   } vec_t;

   vec_t vecs [5];

   initial begin
      int d0;
      // name               r0 c0 r1 c1 p0 p1 mute  top bot hi lo  emp to  ntop nbot ncol
      vecs[0] = '{10,  5,  0,  0, 1, 0, 0,  10, 10,  5,  5, 0, 0,  54, 11, 24};
      vecs[1] = '{63, 23,  0,  0, 1, 1, 0,  63,  0, 23,  0, 0, 0,   1,  1, 24};
      vecs[2] = '{ 0,  0,  0,  0, 0, 0, 0,   0,  0,  0,  0, 1, 0,  64, 64, 24};
      vecs[3] = '{10,  5,  0,  0, 1, 0, 1,  10,  0,  5,  5, 0, 1,  54,  1, 24};
      vecs[4] = '{20,  3, 40, 17, 1, 1, 0,  40, 20, 17,  3, 0, 0,  24, 21, 24};

      clear_bitmap();
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_req", {nextcol, nextrowtop, nextrowbot}, 0);
      chk("rst_idx", {top_idx, bot_idx, col_hi, col_lo, empty, timeout}, 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      for (int v = 0; v < 5; v++) begin
         string nm;
         nm = $sformatf("vec%0d", v);
         clear_bitmap();
         if (vecs[v].p0) bitmap[vecs[v].r0][vecs[v].c0] = 1'b1;
         if (vecs[v].p1) bitmap[vecs[v].r1][vecs[v].c1] = 1'b1;
         mute_bot = vecs[v].mute;
         d0 = done_cnt;
         pulse_start();
         wait_done(nm);
         chk({nm, "_top_idx"}, top_idx, vecs[v].e_top);
         chk({nm, "_bot_idx"}, bot_idx, vecs[v].e_bot);
         chk({nm, "_col_hi"},  col_hi,  vecs[v].e_hi);
         chk({nm, "_col_lo"},  col_lo,  vecs[v].e_lo);
         chk({nm, "_empty"},   empty,   vecs[v].e_empty);
         chk({nm, "_timeout"}, timeout, vecs[v].e_to);
         chk({nm, "_busy_at_done"}, busy, 0);
         @(negedge clk);
         chk({nm, "_done_width"}, done, 0);
         chk({nm, "_done_count"}, done_cnt - d0, 1);
         chk({nm, "_ntop"}, ntop, vecs[v].n_top);
         chk({nm, "_nbot"}, nbot, vecs[v].n_bot);
         chk({nm, "_ncol"}, ncol, vecs[v].n_col);
         chk({nm, "_hold_top"}, top_idx, vecs[v].e_top);
      end
      mute_bot = 1'b0;

      // Reset in the middle of a scan.
      clear_bitmap();
      bitmap[10][5] = 1'b1;
      d0 = done_cnt;
      pulse_start();
      @(negedge clk);
      chk("mid_busy_before_rst", busy, 1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_req", {nextcol, nextrowtop, nextrowbot}, 0);
      chk("mid_rst_outs", {done, empty, timeout, top_idx, bot_idx, col_hi, col_lo}, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (30) @(negedge clk);
      chk("post_rst_reqs", ntop + nbot + ncol, 0);
      chk("post_rst_done", done_cnt - d0, 0);
      chk("post_rst_busy", busy, 0);

      // Restart while busy with a new bitmap.
      d0 = done_cnt;
      pulse_start();
      chk("start_busy_rise", busy, 1);
      chk("start_first_req", {nextcol, nextrowtop, nextrowbot}, 3'b111);
      repeat (20) @(negedge clk);
      clear_bitmap();
      bitmap[30][12] = 1'b1;
      pulse_start();
      chk("abort_busy", busy, 1);
      chk("abort_results_cleared", {top_idx, bot_idx, col_hi, col_lo}, 0);
      wait_done("abort");
      chk("abort_top_idx", top_idx, 30);
      chk("abort_bot_idx", bot_idx, 30);
      chk("abort_col_hi", col_hi, 12);
      chk("abort_col_lo", col_lo, 12);
      chk("abort_empty", empty, 0);
      @(negedge clk);
      chk("abort_done_count", done_cnt - d0, 1);
      chk("abort_ntop", ntop, 34);
      chk("abort_nbot", nbot, 31);
      chk("abort_ncol", ncol, 24);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
